mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 36 +++
 rtl/mem_responder_byte_fifo.sv | 74 +++++++
 rtl/mem_responder.sv | 153 +++++++++++++++
 tb/tb_mem_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared constants and decode helpers for mem_responder.
// The IO path that uses the IO constants is built only when RAM_IO_EN is defined.
package mem_responder_pkg;

   localparam logic        RST_ENABLE     = 1'b1;
   localparam logic [31:0] IO_TX_ADDR     = 32'h0003_0000;
   localparam logic [31:0] IO_STAT_ADDR   = 32'h0003_0004;
   localparam logic [31:0] IO_DECODE_MASK = 32'h0003_0000;

   typedef enum logic [1:0] {
      ACC_RAM      = 2'd0,
      ACC_TX       = 2'd1,
      ACC_STAT     = 2'd2,
      ACC_IO_OTHER = 2'd3
   } acc_kind_e;

   // IO space is any address with both decode-mask bits set; only two IO registers exist
   function automatic acc_kind_e decode_access(input logic [31:0] addr);
      acc_kind_e kind;
      if ((addr & IO_DECODE_MASK) != IO_DECODE_MASK) begin
         kind = ACC_RAM;
      end else if (addr == IO_TX_ADDR) begin
         kind = ACC_TX;
      end else if (addr == IO_STAT_ADDR) begin
         kind = ACC_STAT;
      end else begin
         kind = ACC_IO_OTHER;
      end
      return kind;
   endfunction

   function automatic logic [7:0] status_byte(input logic ovf, input logic full, input logic rx_valid);
      return {5'b00000, ovf, full, rx_valid};
   endfunction

endpackage

// File: rtl/mem_responder_byte_fifo.sv
// Byte-wide TX FIFO with power-of-two depth; pointers wrap naturally modulo DEPTH.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module byte_fifo
   import mem_responder_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          pop,
   output logic [7:0]    head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [7:0]    mem_r [0:DEPTH-1];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign full  = (count_r == CW'(DEPTH));
   assign empty = (count_r == {CW{1'b0}});
   assign count = count_r;
   assign head  = mem_r[rd_ptr_r];

   // Accept/pop qualification; reset blocks any push presented alongside it
   always_comb begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
      if (rst == RST_ENABLE) begin
         do_push_s = 1'b0;
         do_pop_s  = 1'b0;
      end else begin
         do_push_s = push && (!full || pop);
         do_pop_s  = pop && !empty;
      end
   end

   // Storage write, not reset
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/mem_responder.sv
// CPU-facing byte RAM with one-cycle read latency and an optional memory-mapped IO port.
// Define RAM_IO_EN to build the IO path (TX FIFO, RX read, status register).
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH = 17,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ram_addr_i,
   input  logic        ram_wr_i,
   input  logic [7:0]  ram_data_i,
   output logic [7:0]  ram_data_o,
   output logic        rdy_o,
   output logic [7:0]  io_tx_data_o,
   output logic        io_tx_valid_o,
   input  logic        io_tx_ready_i,
   input  logic [7:0]  io_rx_data_i,
   input  logic        io_rx_valid_i,
   output logic        io_rx_pop_o,
   output logic        io_overflow_o
);

   logic [7:0]            ram_r [0:(32'd1 << ADDR_WIDTH) - 32'd1];
   logic [ADDR_WIDTH-1:0] idx_s;
   logic                  ram_we_s;
   logic [7:0]            rd_data_r;
   logic                  rdy_r;

   assign idx_s      = ram_addr_i[ADDR_WIDTH-1:0];
   assign ram_data_o = rd_data_r;

   // RAM array write port; contents survive reset
   always_ff @(posedge clk) begin
      if (ram_we_s) begin
         ram_r[idx_s] <= ram_data_i;
      end
   end

`ifdef RAM_IO_EN
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   acc_kind_e         kind_s;
   logic              push_s;
   logic              pop_s;
   logic              full_s;
   logic              empty_s;
   logic [CNT_W-1:0]  count_s;
   logic [7:0]        head_s;
   logic              ovf_r;
   logic              rx_pop_r;

   assign kind_s        = decode_access(ram_addr_i);
   assign pop_s         = !empty_s && io_tx_ready_i;
   assign io_tx_valid_o = !empty_s;
   assign io_tx_data_o  = head_s;
   assign io_rx_pop_o   = rx_pop_r;
   assign io_overflow_o = ovf_r;
   assign rdy_o         = rdy_r && (count_s != CNT_W'(FIFO_DEPTH));

   // Write steering between RAM and TX FIFO
   always_comb begin
      ram_we_s = 1'b0;
      push_s   = 1'b0;
      if (rst == RST_ENABLE) begin
         ram_we_s = 1'b0;
         push_s   = 1'b0;
      end else begin
         ram_we_s = ram_wr_i && (kind_s == ACC_RAM);
         push_s   = ram_wr_i && (kind_s == ACC_TX);
      end
   end

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_data (ram_data_i),
      .pop       (pop_s),
      .head      (head_s),
      .full      (full_s),
      .empty     (empty_s),
      .count     (count_s)
   );

   // Read data, RX pop strobe, sticky overflow and ready register
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         rd_data_r <= 8'h00;
         rx_pop_r  <= 1'b0;
         ovf_r     <= 1'b0;
         rdy_r     <= 1'b0;
      end else begin
         rdy_r    <= 1'b1;
         rx_pop_r <= 1'b0;
         if (ram_wr_i == 1'b0) begin
            case (kind_s)
               ACC_RAM:  rd_data_r <= ram_r[idx_s];
               ACC_TX: begin
                  rd_data_r <= io_rx_valid_i ? io_rx_data_i : 8'h00;
                  rx_pop_r  <= io_rx_valid_i;
               end
               ACC_STAT: rd_data_r <= status_byte(ovf_r, full_s, io_rx_valid_i);
               default:  rd_data_r <= 8'h00;
            endcase
         end else begin
            // A full FIFO still takes a push when the sink drains a byte that cycle
            case (kind_s)
               ACC_TX:   ovf_r <= ovf_r | (full_s & ~pop_s);
               ACC_STAT: ovf_r <= 1'b0;
               default:  ovf_r <= ovf_r;
            endcase
         end
      end
   end
`else
   logic unused_s;

   assign unused_s      = ^{ram_addr_i, io_tx_ready_i, io_rx_data_i, io_rx_valid_i};
   assign io_tx_valid_o = 1'b0;
   assign io_tx_data_o  = 8'h00;
   assign io_rx_pop_o   = 1'b0;
   assign io_overflow_o = 1'b0;
   assign rdy_o         = rdy_r;

   // Every address is RAM; reset blocks the write
   always_comb begin
      ram_we_s = 1'b0;
      if (rst == RST_ENABLE) begin
         ram_we_s = 1'b0;
      end else begin
         ram_we_s = ram_wr_i;
      end
   end

   // Read data and ready register
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         rd_data_r <= 8'h00;
         rdy_r     <= 1'b0;
      end else begin
         rdy_r <= 1'b1;
         if (ram_wr_i == 1'b0) begin
            rd_data_r <= ram_r[idx_s];
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Randomised self-checking bench for mem_responder against a queue/array reference model.
// Covers both builds; IO scenarios are compiled only with RAM_IO_EN.
module tb_mem_responder;

   localparam int DEPTH = 8;
`ifdef RAM_IO_EN
   localparam bit IO_EN = 1'b1;
`else
   localparam bit IO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ram_addr_i;
   logic        ram_wr_i;
   logic [7:0]  ram_data_i;
   logic [7:0]  ram_data_o;
   logic        rdy_o;
   logic [7:0]  io_tx_data_o;
   logic        io_tx_valid_o;
   logic        io_tx_ready_i;
   logic [7:0]  io_rx_data_i;
   logic        io_rx_valid_i;
   logic        io_rx_pop_o;
   logic        io_overflow_o;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [7:0] ref_ram [int];
   logic [7:0] ref_q [$];
   bit         m_ovf      = 1'b0;
   bit         m_rdy_reg  = 1'b0;
   bit         m_rxpop    = 1'b0;
   logic [7:0] m_rd       = 8'h00;
   bit         m_rd_known = 1'b0;
   bit         m_rd_chk   = 1'b0;

   mem_responder dut (
      .clk           (clk),
      .rst           (rst),
      .ram_addr_i    (ram_addr_i),
      .ram_wr_i      (ram_wr_i),
      .ram_data_i    (ram_data_i),
      .ram_data_o    (ram_data_o),
      .rdy_o         (rdy_o),
      .io_tx_data_o  (io_tx_data_o),
      .io_tx_valid_o (io_tx_valid_o),
      .io_tx_ready_i (io_tx_ready_i),
      .io_rx_data_i  (io_rx_data_i),
      .io_rx_valid_i (io_rx_valid_i),
      .io_rx_pop_o   (io_rx_pop_o),
      .io_overflow_o (io_overflow_o)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply the behaviour of one rising edge to the model, from the inputs now on the pins
   task automatic model_edge();
      bit is_io;
      bit pop;
      int idx;
      is_io    = IO_EN && (ram_addr_i[17:16] == 2'b11);
      idx      = int'(ram_addr_i[16:0]);
      pop      = (ref_q.size() > 0) && io_tx_ready_i;
      m_rd_chk = 1'b0;
      m_rxpop  = 1'b0;
      if (rst) begin
         ref_q.delete();
         m_ovf      = 1'b0;
         m_rdy_reg  = 1'b0;
         m_rd       = 8'h00;
         m_rd_known = 1'b1;
         m_rd_chk   = 1'b1;
      end else begin
         m_rdy_reg = 1'b1;
         if (ram_wr_i) begin
            if (!is_io) begin
               ref_ram[idx] = ram_data_i;
            end else if (ram_addr_i == 32'h0003_0000) begin
               if (ref_q.size() < DEPTH || pop) begin
                  if (pop) void'(ref_q.pop_front());
                  pop = 1'b0;
                  ref_q.push_back(ram_data_i);
               end else begin
                  m_ovf = 1'b1;
               end
            end else if (ram_addr_i == 32'h0003_0004) begin
               m_ovf = 1'b0;
            end
         end else begin
            m_rd_chk   = 1'b1;
            m_rd_known = 1'b1;
            if (!is_io) begin
               m_rd_known = ref_ram.exists(idx);
               if (m_rd_known) m_rd = ref_ram[idx];
            end else if (ram_addr_i == 32'h0003_0000) begin
               m_rd    = io_rx_valid_i ? io_rx_data_i : 8'h00;
               m_rxpop = io_rx_valid_i;
            end else if (ram_addr_i == 32'h0003_0004) begin
               m_rd = {5'b00000, m_ovf, ref_q.size() == DEPTH, io_rx_valid_i};
            end else begin
               m_rd = 8'h00;
            end
         end
         if (pop) void'(ref_q.pop_front());
      end
   endtask

   task automatic check_outputs();
      check_val("rdy", 32'(rdy_o), 32'(m_rdy_reg && ref_q.size() != DEPTH));
      check_val("tx_valid", 32'(io_tx_valid_o), 32'(ref_q.size() != 0));
      if (ref_q.size() != 0) check_val("tx_data", 32'(io_tx_data_o), 32'(ref_q[0]));
      check_val("rx_pop", 32'(io_rx_pop_o), 32'(m_rxpop));
      check_val("overflow", 32'(io_overflow_o), 32'(m_ovf));
      if (m_rd_chk && m_rd_known) check_val("rd_data", 32'(ram_data_o), 32'(m_rd));
   endtask

   // One access: drive pins, advance the model, step past the edge, compare
   task automatic cycle(input logic [31:0] a, input logic w, input logic [7:0] d);
      ram_addr_i = a;
      ram_wr_i   = w;
      ram_data_i = d;
      model_edge();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   initial begin
      rst = 1'b1; ram_addr_i = 32'h0; ram_wr_i = 1'b0; ram_data_i = 8'h00;
      io_tx_ready_i = 1'b0; io_rx_data_i = 8'h00; io_rx_valid_i = 1'b0;

      repeat (3) cycle(32'h0, 1'b0, 8'h00);
      check_val("reset_rd", 32'(ram_data_o), 32'h00);
      check_val("reset_rdy", 32'(rdy_o), 32'h0);
      rst = 1'b0;
      cycle(32'h0000_0010, 1'b1, 8'hA5);
      check_val("first_rdy", 32'(rdy_o), 32'h1);
      cycle(32'h0000_0010, 1'b0, 8'h00);
      check_val("ram_rd_a5", 32'(ram_data_o), 32'hA5);

`ifdef RAM_IO_EN
      io_tx_ready_i = 1'b1;
      cycle(32'h0003_0000, 1'b1, 8'h41);
      check_val("tx_valid_41", 32'(io_tx_valid_o), 32'h1);
      check_val("tx_data_41", 32'(io_tx_data_o), 32'h41);
      cycle(32'h0003_0008, 1'b0, 8'h00);
      check_val("tx_drained", 32'(io_tx_valid_o), 32'h0);

      io_tx_ready_i = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         cycle(32'h0003_0000, 1'b1, 8'(i));
         if (i == 8) check_val("full_rdy", 32'(rdy_o), 32'h0);
      end
      check_val("ovf_set", 32'(io_overflow_o), 32'h1);
      check_val("head_01", 32'(io_tx_data_o), 32'h01);
      cycle(32'h0003_0004, 1'b0, 8'h00);
      check_val("stat_06", 32'(ram_data_o), 32'h06);

      cycle(32'h0003_0004, 1'b1, 8'hFF);
      check_val("ovf_clear", 32'(io_overflow_o), 32'h0);
      io_tx_ready_i = 1'b1;
      cycle(32'h0003_0000, 1'b1, 8'h55);
      io_tx_ready_i = 1'b0;
      check_val("pushpop_rdy", 32'(rdy_o), 32'h0);
      check_val("pushpop_ovf", 32'(io_overflow_o), 32'h0);
      check_val("pushpop_head", 32'(io_tx_data_o), 32'h02);
      io_tx_ready_i = 1'b1;
      repeat (7) cycle(32'h0003_0008, 1'b0, 8'h00);
      check_val("last_55", 32'(io_tx_data_o), 32'h55);
      cycle(32'h0003_0008, 1'b0, 8'h00);
      check_val("empty_after", 32'(io_tx_valid_o), 32'h0);
      io_tx_ready_i = 1'b0;

      io_rx_valid_i = 1'b1; io_rx_data_i = 8'h7E;
      cycle(32'h0003_0000, 1'b0, 8'h00);
      check_val("rx_7e", 32'(ram_data_o), 32'h7E);
      check_val("rx_pop_on", 32'(io_rx_pop_o), 32'h1);
      cycle(32'h0000_0010, 1'b0, 8'h00);
      check_val("rx_pop_off", 32'(io_rx_pop_o), 32'h0);
      io_rx_valid_i = 1'b0;
`endif

      io_tx_ready_i = 1'b0;
      cycle(32'h0000_0020, 1'b1, 8'h11);
      for (int i = 0; i < 3; i++) cycle(32'h0003_0000, 1'b1, 8'hC0 + 8'(i));
      rst = 1'b1;
      cycle(32'h0003_0000, 1'b1, 8'hEE);
      check_val("rst_tx_valid", 32'(io_tx_valid_o), 32'h0);
      check_val("rst_rdy", 32'(rdy_o), 32'h0);
      cycle(32'h0000_0020, 1'b1, 8'h22);
      rst = 1'b0;
      cycle(32'h0000_0020, 1'b0, 8'h00);
      check_val("post_rst_rdy", 32'(rdy_o), 32'h1);
      check_val("rst_no_write", 32'(ram_data_o), 32'h11);

      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a;
         int sel;
         sel = int'($urandom_range(0, 9));
         case (sel)
            5, 6:    a = 32'h0003_0000;
            7:       a = 32'h0003_0004;
            8:       a = 32'h0003_0008;
            9:       a = 32'h0007_0010;
            default: a = 32'($urandom_range(0, 63));
         endcase
         rst           = ($urandom_range(0, 99) == 0);
         io_tx_ready_i = ($urandom_range(0, 3) == 0);
         io_rx_valid_i = $urandom_range(0, 1) == 1;
         io_rx_data_i  = 8'($urandom);
         cycle(a, $urandom_range(0, 1) == 1, 8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
